// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and widths for the instruction fetch stage
package fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam int OFFSET_W = 16;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXEC, S_ERR} state_t;
endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: sequential or jump-relative next pc from a signed word offset
module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic [ADDR_W-1:0]   pc,
  input  logic                jump,
  input  logic [OFFSET_W-1:0] jump_offset,
  output logic [ADDR_W-1:0]   next_pc
);
  logic [ADDR_W-1:0] off_bytes;
  // word offset sign-extended and scaled to bytes; the sum wraps mod 2^32
  assign off_bytes = {{(ADDR_W-OFFSET_W-2){jump_offset[OFFSET_W-1]}}, jump_offset, 2'b00};
  assign next_pc = pc + PC_STEP + (jump ? off_bytes : '0);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: pc register, req/valid instruction fetch and timeout watchdog
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_valid,
  output logic [INSTR_W-1:0]  instruction,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc,
  input  logic                jump,
  input  logic [OFFSET_W-1:0] jump_offset,
  input  logic                stall,
  output logic                fetch_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] pc_nx, pc_seq;
  logic [INSTR_W-1:0] instr_nx;
  fetch_pc_next u_pc_next (
    .pc(pc),
    .jump(jump),
    .jump_offset(jump_offset),
    .next_pc(pc_seq)
  );
  // state, wait counter, pc and captured instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      pc <= RESET_PC;
      instruction <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      pc <= pc_nx;
      instruction <= instr_nx;
    end
  end
  // fetch sequencing: request until valid or timeout, then execute until unstalled
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    pc_nx = pc;
    instr_nx = instruction;
    case (state)
      S_IDLE: state_nx = S_REQ;
      S_REQ:
        if (imem_valid) begin
          instr_nx = imem_rdata;
          cnt_nx = '0;
          state_nx = S_EXEC;
        end else if (cnt == CW'(TIMEOUT - 1)) state_nx = S_ERR;
        else cnt_nx = cnt + 1'b1;
      S_EXEC:
        if (!stall) begin
          pc_nx = pc_seq;
          state_nx = S_REQ;
        end
      default: state_nx = S_ERR;
    endcase
  end
  assign imem_req = state == S_REQ;
  assign imem_addr = pc;
  assign instr_valid = state == S_EXEC;
  assign fetch_err = state == S_ERR;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random fetch checks against a behavioural model
module tb_instr_fetch;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 0, rst_n = 0;
  logic imem_req, imem_valid = 0, instr_valid, jump = 0, stall = 0, fetch_err;
  logic [31:0] imem_addr, imem_rdata = 0, instruction, pc;
  logic [15:0] jump_offset = 0;
  int vectors = 0, fails = 0;
  logic [31:0] rom [256];
  int lat = 0, wcnt = 0;
  bit silent = 0, rnd_lat = 0;
  logic [31:0] m_pc, m_instr;
  bit m_started, m_have, m_err;
  int m_waited;

  instr_fetch #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .jump(jump), .jump_offset(jump_offset),
    .stall(stall), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 0; m_started = 0; m_have = 0; m_err = 0; m_waited = 0;
  endtask

  // one clock edge of the reference: what the stage must do given these inputs
  task automatic model_step(input bit s, input bit j, input logic [15:0] o, input bit v);
    shortint so;
    so = o;
    if (!m_started) m_started = 1;
    else if (m_err) begin end
    else if (!m_have) begin
      if (v) begin m_instr = rom[m_pc[9:2]]; m_have = 1; m_waited = 0; end
      else begin m_waited++; if (m_waited == TIMEOUT) m_err = 1; end
    end else if (!s) begin
      m_pc = m_pc + 32'(4 + (j ? 4 * int'(so) : 0));
      m_have = 0;
    end
  endtask

  task automatic compare();
    chk("imem_req", imem_req, m_started && !m_have && !m_err);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("instr_valid", instr_valid, m_have && !m_err);
    chk("fetch_err", fetch_err, m_err);
    chk("instruction", instruction, m_instr);
  endtask

  // called at a negedge: drive inputs and memory, advance model, check next negedge
  task automatic step(input bit s, input bit j, input logic [15:0] o);
    stall = s; jump = j; jump_offset = o;
    if (imem_req) begin
      imem_valid = !silent && (wcnt >= lat);
      imem_rdata = imem_valid ? rom[imem_addr[9:2]] : $urandom;
      wcnt = imem_valid ? 0 : wcnt + 1;
      if (imem_valid && rnd_lat) lat = $urandom_range(0, 3);
    end else begin
      wcnt = 0;
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
    model_step(s, j, o, imem_valid);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_n = 0;
    imem_valid = 1;
    imem_rdata = $urandom;
    model_reset();
    #1 chk("rst_async_req", imem_req, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    imem_valid = 0;
    wcnt = 0;
    compare();
  endtask

  task automatic wait_exec();
    int n = 0;
    while (!instr_valid && n < 40) begin step(0, 0, 0); n++; end
    chk("wait_exec", instr_valid, 1);
  endtask

  task automatic advance(input bit j, input logic [15:0] o);
    step(0, j, o);
    wait_exec();
  endtask

  initial begin
    logic [31:0] addrs [$];
    int n;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    @(negedge clk);
    do_reset();
    chk("rst_instr", instruction, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_addr", imem_addr, 32'h0);
    // zero-wait sequential fetch
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      if (imem_req) addrs.push_back(imem_addr);
      if (instr_valid) n++;
    end
    chk("seq_count", addrs.size(), 4);
    for (int i = 0; i < addrs.size(); i++) chk("seq_addr", addrs[i], 32'(4 * i));
    chk("seq_valid_pulses", n, 4);
    // three wait states at address 4
    do_reset();
    wait_exec();
    chk("rom0", instruction, rom[0]);
    lat = 3;
    step(0, 0, 0);
    n = 0;
    while (imem_req && n < 20) begin
      chk("wait_addr", imem_addr, 32'h4);
      n++;
      step(0, 0, 0);
    end
    chk("wait_req_cycles", n, 4);
    chk("wait_valid", instr_valid, 1);
    chk("wait_err", fetch_err, 0);
    chk("rom1", instruction, rom[1]);
    lat = 0;
    // jumps forward and backward
    repeat (3) advance(0, 0);
    chk("pc_10", pc, 32'h10);
    advance(1, 16'h0003);
    chk("jump_fwd", imem_addr, 32'h20);
    advance(1, 16'hFFF8);
    chk("jump_back", imem_addr, 32'h04);
    // stall holds instruction and ignores jump
    advance(0, 0);
    chk("pc_8", pc, 32'h8);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 16'h1);
      chk("stall_pc", pc, 32'h8);
      chk("stall_req", imem_req, 0);
      chk("stall_instr", instruction, rom[2]);
    end
    advance(1, 16'h1);
    chk("stall_jump", imem_addr, 32'h10);
    // watchdog timeout
    silent = 1;
    step(0, 0, 0);
    n = 0;
    while (imem_req && n < 40) begin n++; step(0, 0, 0); end
    chk("timeout_cycles", n, 16);
    chk("timeout_err", fetch_err, 1);
    repeat (3) step(0, 0, 0);
    chk("err_sticky", fetch_err, 1);
    chk("err_noreq", imem_req, 0);
    silent = 0;
    do_reset();
    step(0, 0, 0);
    chk("restart_addr", imem_addr, RESET_PC);
    chk("restart_err", fetch_err, 0);
    // reset mid-wait at 0xC, then pc wrap
    wait_exec();
    repeat (2) advance(0, 0);
    lat = 10;
    repeat (3) step(0, 0, 0);
    chk("midwait_addr", imem_addr, 32'hC);
    do_reset();
    lat = 0;
    step(0, 0, 0);
    chk("after_rst_addr", imem_addr, RESET_PC);
    wait_exec();
    advance(1, 16'hFFFE);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    advance(0, 0);
    chk("wrap_zero", pc, 32'h0);
    // randomized traffic
    rnd_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] o;
      o = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(0, 8) - 4);
      if ($urandom % 700 == 0) do_reset();
      step(($urandom % 4) == 0, 1'($urandom % 2), o);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage of the single-cycle CPU, directly upstream of the decoder/control unit. It holds the program counter and fetches one 32-bit word per instruction from instruction memory over a req/valid handshake. It presents the word to the control unit, then consumes that unit's jump/jump_offset outputs to form the next PC. A watchdog flags a fetch that never completes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles a fetch may wait for imem_valid before error (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  byte address of fetch (= pc)
imem_rdata  input  32  fetched word, valid when imem_valid=1
imem_valid  input  1  memory response strobe
instruction  output  32  registered instruction to control unit
instr_valid  output  1  instruction is current and executing
pc  output  32  address of current instruction
jump  input  1  from control unit: take jump
jump_offset  input  16  from control unit: signed word offset
stall  input  1  hold current instruction (e.g. multi-cycle RAM access)
fetch_err  output  1  sticky fetch timeout flag

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=S_IDLE, imem_req=0, instruction=0, instr_valid=0, fetch_err=0, wait counter=0. imem_addr follows pc.
- States: S_IDLE, S_REQ, S_EXEC, S_ERR.
- S_IDLE: entered only from reset; next cycle -> S_REQ.
- S_REQ: imem_req=1, imem_addr=pc held stable. Sample imem_valid each cycle, including the first (a zero-wait memory may answer in the same cycle).
  - imem_valid=1: instruction<=imem_rdata, counter<=0, -> S_EXEC (instr_valid=1 from the next cycle).
  - else counter++. When counter reaches TIMEOUT-1 with no valid: -> S_ERR.
- S_EXEC: imem_req=0, instr_valid=1, instruction and pc stable.
  - stall=1: remain; jump/jump_offset ignored.
  - stall=0: pc<=next_pc, instr_valid<=0, -> S_REQ.
- next_pc = jump ? pc + 4 + {{14{jump_offset[15]}}, jump_offset, 2'b00} : pc + 4. All arithmetic is mod 2^32 (wraps silently). pc[1:0] stays 00 when RESET_PC is aligned.
- jump and jump_offset are sampled only in the S_EXEC cycle with stall=0. Other values are don't-care.
- S_ERR: imem_req=0, instr_valid=0, fetch_err=1. Sticky until rst_n.
- imem_valid outside S_REQ is ignored; instruction is not updated.
- Throughput: 2 cycles per instruction minimum (zero-wait memory, no stall). Each memory wait state adds 1 cycle; each stall cycle adds 1 cycle.
- Reset asserted mid-fetch drops imem_req immediately (async). The outstanding response is ignored because the state is S_IDLE.
- Stall asserted during S_REQ has no effect; it only acts in S_EXEC.

Decomposition:
- Shared package fetch_pkg: state encoding (S_IDLE, S_REQ, S_EXEC, S_ERR), PC_STEP=4, instruction width 32, offset width 16.
- One combinational sub-module fetch_pc_next (pc, jump, jump_offset -> next_pc), reusable by a future branch unit.

Test Plan:
- Reset, RESET_PC=0, zero-wait ROM, no jump -> imem_addr sequence 0,4,8,C; instr_valid pulses 1 cycle out of every 2; instruction matches ROM words.
- Memory with 3 wait states at addr 4 -> imem_req high 4 cycles with addr 4 stable; instr_valid rises the cycle after imem_valid; no error.
- At pc=0x10: jump=1, offset=16'h0003 -> next imem_addr 0x20. At pc=0x20: offset=16'hFFF8 -> next imem_addr 0x04.
- stall=1 for 5 cycles in S_EXEC at pc=8 with jump=1, offset=1 held -> instruction/pc constant, no imem_req. stall drops -> next imem_addr 0x10.
- TIMEOUT=16, imem_valid never asserted -> after 16 req cycles: imem_req=0, fetch_err=1, stays set. rst_n pulse clears it and fetch restarts at RESET_PC.
- rst_n asserted during a wait at pc=0xC, then imem_valid arrives -> response ignored; after release, first imem_addr=RESET_PC; pc=0xFFFF_FFFC +4 wraps to 0.
